// File: rtl/mem_stage_pkg.sv
// Shared opcodes, state encoding and data-port command layout for the MEM stage.
// Pure declarations; no latency or flow control lives here.
package mem_stage_pkg;

   localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
   localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   localparam logic [4:0]  NOPREGADDR = 5'b00000;
   localparam logic [31:0] ZEROWORD   = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] addr;
   } dm_cmd_t;

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data port: byte enables, store replication, load extraction.
// Purely combinational, zero latency; no flow control.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [7:0]  aluop,
   input  logic [1:0]  offset,
   input  logic [31:0] rt,
   input  logic [31:0] rdata,
   output logic        is_mem,
   output logic        is_store,
   output logic        misaligned,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Big-endian: offset 0 is the most significant byte lane.
   always_comb begin
      byte_v = rdata[31:24];
      case (offset)
         2'd0: byte_v = rdata[31:24];
         2'd1: byte_v = rdata[23:16];
         2'd2: byte_v = rdata[15:8];
         2'd3: byte_v = rdata[7:0];
         default: byte_v = rdata[31:24];
      endcase
      half_v = offset[1] ? rdata[15:0] : rdata[31:16];
   end

   always_comb begin
      is_mem     = 1'b0;
      is_store   = 1'b0;
      misaligned = 1'b0;
      sel        = 4'b0000;
      wdata      = ZEROWORD;
      load_data  = ZEROWORD;
      case (aluop)
         EXE_LB_OP, EXE_LBU_OP: begin
            is_mem    = 1'b1;
            sel       = 4'b1000 >> offset;
            load_data = (aluop == EXE_LB_OP) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
         end
         EXE_LH_OP, EXE_LHU_OP: begin
            is_mem     = 1'b1;
            misaligned = offset[0];
            sel        = offset[1] ? 4'b0011 : 4'b1100;
            load_data  = (aluop == EXE_LH_OP) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
         end
         EXE_LW_OP: begin
            is_mem     = 1'b1;
            misaligned = |offset;
            sel        = 4'b1111;
            load_data  = rdata;
         end
         EXE_SB_OP: begin
            is_mem   = 1'b1;
            is_store = 1'b1;
            sel      = 4'b1000 >> offset;
            wdata    = {4{rt[7:0]}};
         end
         EXE_SH_OP: begin
            is_mem     = 1'b1;
            is_store   = 1'b1;
            misaligned = offset[0];
            sel        = offset[1] ? 4'b0011 : 4'b1100;
            wdata      = {2{rt[15:0]}};
         end
         EXE_SW_OP: begin
            is_mem     = 1'b1;
            is_store   = 1'b1;
            misaligned = |offset;
            sel        = 4'b1111;
            wdata      = rt;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU passthrough (0 cycles) or req/ack data access (>= 3 cycles).
// Holds the pipeline via stallreq while a transfer is pending; abandons it after ACK_TIMEOUT waits.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic [7:0]  ex_aluop,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_reg2,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        stallreq,
   output logic        addr_err,
   output logic        bus_err,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_sel,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack
);

   localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

   mem_state_t  state;
   logic [7:0]  cnt;
   logic        err_q;
   logic        req_q;
   logic [31:0] rbuf;
   dm_cmd_t     cmd_q;

   logic        is_mem, is_store, misaligned;
   logic [3:0]  al_sel;
   logic [31:0] al_wdata, al_load;
   logic        go;

   mem_align u_align (
      .aluop      (ex_aluop),
      .offset     (ex_mem_addr[1:0]),
      .rt         (ex_reg2),
      .rdata      (dm_rdata),
      .is_mem     (is_mem),
      .is_store   (is_store),
      .misaligned (misaligned),
      .sel        (al_sel),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   assign go = (state == ST_IDLE) && is_mem && !misaligned;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 8'd0;
         err_q <= 1'b0;
         req_q <= 1'b0;
         rbuf  <= ZEROWORD;
         cmd_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (go) begin
                  state       <= ST_WAIT;
                  cnt         <= 8'd0;
                  err_q       <= 1'b0;
                  req_q       <= 1'b1;
                  cmd_q.we    <= is_store;
                  cmd_q.sel   <= al_sel;
                  cmd_q.wdata <= al_wdata;
                  cmd_q.addr  <= {ex_mem_addr[31:2], 2'b00};
               end
            end
            ST_WAIT: begin
               cnt <= cnt + 8'd1;
               // An ack on the final permitted cycle still wins over the timeout.
               if (dm_ack) begin
                  rbuf  <= al_load;
                  req_q <= 1'b0;
                  state <= ST_DONE;
               end else if (cnt == TO_LAST) begin
                  err_q <= 1'b1;
                  req_q <= 1'b0;
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_wd    = NOPREGADDR;
      mem_wreg  = 1'b0;
      mem_wdata = ZEROWORD;
      stallreq  = 1'b0;
      addr_err  = 1'b0;
      bus_err   = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               mem_wd    = ex_wd;
               mem_wdata = ex_wdata;
               mem_wreg  = ex_wreg && !is_mem;
               stallreq  = go;
               addr_err  = is_mem && misaligned;
            end
            ST_WAIT: begin
               mem_wd    = ex_wd;
               mem_wdata = ex_wdata;
               stallreq  = 1'b1;
            end
            ST_DONE: begin
               mem_wd    = ex_wd;
               mem_wdata = ex_wdata;
               bus_err   = err_q;
               if (!cmd_q.we && !err_q) begin
                  mem_wreg  = ex_wreg;
                  mem_wdata = rbuf;
               end
            end
            default: ;
         endcase
      end
   end

   assign dm_req   = req_q;
   assign dm_we    = cmd_q.we;
   assign dm_sel   = cmd_q.sel;
   assign dm_wdata = cmd_q.wdata;
   assign dm_addr  = cmd_q.addr;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops against a lane model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  ex_wd = '0;
   logic        ex_wreg = 1'b0;
   logic [31:0] ex_wdata = '0;
   logic [7:0]  ex_aluop = '0;
   logic [31:0] ex_mem_addr = '0;
   logic [31:0] ex_reg2 = '0;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq, addr_err, bus_err;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_sel;
   logic [31:0] dm_rdata = '0;
   logic        dm_ack = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
      .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .stallreq(stallreq), .addr_err(addr_err), .bus_err(bus_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [7:0] op);
      if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
      if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
      if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
      return 0;
   endfunction

   function automatic bit op_store(input logic [7:0] op);
      return (op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP);
   endfunction

   function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      int k = int'(addr % 4);
      logic [7:0]  b = 8'(rdata >> (8 * (3 - k)));
      logic [15:0] h = 16'(rdata >> (16 * (1 - k / 2)));
      case (op)
         EXE_LB_OP:  return 32'($signed(b));
         EXE_LBU_OP: return 32'(b);
         EXE_LH_OP:  return 32'($signed(h));
         EXE_LHU_OP: return 32'(h);
         default:    return rdata;
      endcase
   endfunction

   function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
      int k = int'(addr % 4);
      case (op_size(op))
         1:       return 4'(1 << (3 - k));
         2:       return (k < 2) ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] rt);
      case (op_size(op))
         1:       return 32'(rt[7:0]) * 32'h0101_0101;
         2:       return 32'(rt[15:0]) * 32'h0001_0001;
         default: return rt;
      endcase
   endfunction

   // ---------------- stimulus driver (observes, does not judge) ----------------
   int          obs_cycles, obs_stall, obs_req, obs_buserr, obs_addrerr;
   bit          obs_done;
   logic [4:0]  obs_wd;
   logic        obs_wreg, obs_we;
   logic [31:0] obs_wdata, obs_dm_wdata, obs_dm_addr;
   logic [3:0]  obs_sel;

   // Called just after a rising edge with the DUT in IDLE; returns just after the edge ending DONE.
   // delay < 0 means the memory never acknowledges.
   task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] alu,
                         input logic [31:0] rdata, input int delay, input bit noise);
      bit seen = 0;
      ex_aluop = op; ex_mem_addr = addr; ex_reg2 = rt;
      ex_wd = wd; ex_wreg = wreg; ex_wdata = alu;
      obs_cycles = 0; obs_stall = 0; obs_req = 0; obs_buserr = 0; obs_addrerr = 0; obs_done = 0;
      for (int c = 0; c < 20 && !obs_done; c++) begin
         @(negedge clk);
         obs_cycles++;
         obs_stall   += int'(stallreq);
         obs_buserr  += int'(bus_err);
         obs_addrerr += int'(addr_err);
         if (dm_req) begin
            seen = 1;
            obs_req++;
            obs_sel = dm_sel; obs_we = dm_we; obs_dm_wdata = dm_wdata; obs_dm_addr = dm_addr;
            if (delay >= 0 && obs_req == delay + 1) begin
               dm_ack = 1'b1; dm_rdata = rdata;
            end else begin
               dm_ack = 1'b0; dm_rdata = $urandom;
            end
         end else begin
            if (seen) begin
               obs_done = 1;
               obs_wd = mem_wd; obs_wreg = mem_wreg; obs_wdata = mem_wdata;
            end
            dm_ack   = noise ? 1'($urandom) : 1'b0;
            dm_rdata = $urandom;
         end
         @(posedge clk); #1;
      end
      dm_ack = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      ex_aluop = EXE_ADD_OP; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (mem_wd !== NOPREGADDR) begin n_fail++; $display("FAIL reset_mem_wd: got %0d want 0", mem_wd); end
      n_checks++;
      if ({mem_wreg, mem_wdata, stallreq, addr_err, bus_err} !== '0) begin
         n_fail++; $display("FAIL reset_wb_outputs: got wreg=%b wdata=%h stall=%b aerr=%b berr=%b want all 0",
                            mem_wreg, mem_wdata, stallreq, addr_err, bus_err);
      end
      n_checks++;
      if ({dm_req, dm_we, dm_addr, dm_sel, dm_wdata} !== '0) begin
         n_fail++; $display("FAIL reset_dm_outputs: got req=%b we=%b addr=%h sel=%b wdata=%h want all 0",
                            dm_req, dm_we, dm_addr, dm_sel, dm_wdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      ex_aluop = EXE_ADD_OP; ex_wdata = 32'h1234_5678; ex_wd = 5'd3; ex_wreg = 1'b1;
      #1;
      n_checks++;
      if ({mem_wd, mem_wreg, mem_wdata} !== {5'd3, 1'b1, 32'h1234_5678}) begin
         n_fail++; $display("FAIL add_passthrough: got wd=%0d wreg=%b wdata=%h want 3/1/12345678", mem_wd, mem_wreg, mem_wdata);
      end
      n_checks++;
      if (stallreq !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b want 0", stallreq); end
      @(posedge clk); #1;
   endtask

   task automatic test_lb();
      run_op(EXE_LB_OP, 32'h101, 32'h0, 5'd9, 1'b1, 32'h0, 32'h11F2_3344, 0, 0);
      n_checks++;
      if (obs_wdata !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL lb_data: got %h want fffffff2", obs_wdata); end
      n_checks++;
      if (obs_stall !== 2) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want 2", obs_stall); end
      n_checks++;
      if (obs_cycles !== 3 || obs_wreg !== 1'b1 || obs_wd !== 5'd9) begin
         n_fail++; $display("FAIL lb_done: got cycles=%0d wreg=%b wd=%0d want 3/1/9", obs_cycles, obs_wreg, obs_wd);
      end
      n_checks++;
      if (obs_sel !== 4'b0100) begin n_fail++; $display("FAIL lb_sel: got %b want 0100", obs_sel); end
      run_op(EXE_LBU_OP, 32'h101, 32'h0, 5'd9, 1'b1, 32'h0, 32'h11F2_3344, 0, 0);
      n_checks++;
      if (obs_wdata !== 32'h0000_00F2) begin n_fail++; $display("FAIL lbu_data: got %h want 000000f2", obs_wdata); end
   endtask

   task automatic test_sh();
      run_op(EXE_SH_OP, 32'h202, 32'hAAAA_BEEF, 5'd4, 1'b0, 32'h0, 32'h0, 0, 0);
      n_checks++;
      if (obs_sel !== 4'b0011) begin n_fail++; $display("FAIL sh_sel: got %b want 0011", obs_sel); end
      n_checks++;
      if (obs_dm_wdata !== 32'hBEEF_BEEF || obs_we !== 1'b1) begin
         n_fail++; $display("FAIL sh_write: got wdata=%h we=%b want beefbeef/1", obs_dm_wdata, obs_we);
      end
      n_checks++;
      if (obs_dm_addr !== 32'h200) begin n_fail++; $display("FAIL sh_addr: got %h want 00000200", obs_dm_addr); end
      n_checks++;
      if (obs_wreg !== 1'b0 || !obs_done) begin n_fail++; $display("FAIL sh_done_wreg: got %b done=%0d want 0/1", obs_wreg, obs_done); end
   endtask

   task automatic test_misaligned();
      int reqs = 0, errs = 0, stalls = 0;
      ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h103; ex_wd = 5'd5; ex_wreg = 1'b1;
      @(negedge clk);
      errs += int'(addr_err); stalls += int'(stallreq); reqs += int'(dm_req);
      n_checks++;
      if (mem_wreg !== 1'b0) begin n_fail++; $display("FAIL misalign_wreg: got %b want 0", mem_wreg); end
      @(posedge clk); #1;
      ex_aluop = EXE_ADD_OP;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         errs += int'(addr_err); stalls += int'(stallreq); reqs += int'(dm_req);
         @(posedge clk); #1;
      end
      n_checks++;
      if (errs !== 1) begin n_fail++; $display("FAIL misalign_addr_err: got %0d pulses want 1", errs); end
      n_checks++;
      if (reqs !== 0 || stalls !== 0) begin n_fail++; $display("FAIL misalign_no_req: got req=%0d stall=%0d want 0/0", reqs, stalls); end
   endtask

   task automatic test_timeout();
      run_op(EXE_LW_OP, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0, -1, 0);
      n_checks++;
      if (obs_req !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 4", obs_req); end
      n_checks++;
      if (obs_buserr !== 1 || !obs_done) begin n_fail++; $display("FAIL timeout_bus_err: got %0d pulses done=%0d want 1/1", obs_buserr, obs_done); end
      n_checks++;
      if (obs_wreg !== 1'b0 || obs_cycles !== 6) begin
         n_fail++; $display("FAIL timeout_done: got wreg=%b cycles=%0d want 0/6", obs_wreg, obs_cycles);
      end
      ex_aluop = EXE_ADD_OP; ex_wdata = 32'hCAFE_0001;
      #1;
      n_checks++;
      if (stallreq !== 1'b0 || mem_wreg !== 1'b1 || mem_wdata !== 32'hCAFE_0001 || bus_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_back_idle: got stall=%b wreg=%b wdata=%h berr=%b want 0/1/cafe0001/0",
                            stallreq, mem_wreg, mem_wdata, bus_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight();
      int reqs = 0;
      ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h300; ex_wd = 5'd8; ex_wreg = 1'b1; ex_wdata = 32'h5555_AAAA;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         reqs += int'(dm_req);
         if (c == 2) rst = 1'b1;
         @(posedge clk); #1;
      end
      n_checks++;
      if (reqs !== 2) begin n_fail++; $display("FAIL midreset_pre_req: got %0d want 2", reqs); end
      @(negedge clk);
      n_checks++;
      if (dm_req !== 1'b0 || stallreq !== 1'b0) begin n_fail++; $display("FAIL midreset_drop: got req=%b stall=%b want 0/0", dm_req, stallreq); end
      n_checks++;
      if ({mem_wd, mem_wreg, mem_wdata, addr_err, bus_err, dm_we, dm_addr, dm_sel, dm_wdata} !== '0) begin
         n_fail++; $display("FAIL midreset_outputs: got wd=%0d wreg=%b wdata=%h sel=%b addr=%h want all 0",
                            mem_wd, mem_wreg, mem_wdata, dm_sel, dm_addr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(EXE_LW_OP, 32'h300, 32'h0, 5'd8, 1'b1, 32'h0, 32'h8765_4321, 1, 0);
      n_checks++;
      if (obs_wdata !== 32'h8765_4321 || obs_wreg !== 1'b1 || obs_stall !== 3) begin
         n_fail++; $display("FAIL midreset_after_lw: got wdata=%h wreg=%b stall=%0d want 87654321/1/3", obs_wdata, obs_wreg, obs_stall);
      end
   endtask

   task automatic test_random();
      logic [7:0] ops [9];
      ops = '{EXE_ADD_OP, EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
      for (int i = 0; i < 60; i++) begin
         logic [7:0]  op    = ops[$urandom_range(0, 8)];
         logic [31:0] addr  = $urandom;
         logic [31:0] rt    = $urandom;
         logic [31:0] rdata = $urandom;
         logic [31:0] alu   = $urandom;
         logic [4:0]  wd    = 5'($urandom);
         logic        wreg  = 1'($urandom);
         int          dly   = $urandom_range(0, 2);
         int          sz    = op_size(op);
         if (i % 3 == 0 && sz != 0) addr = addr & ~32'(sz - 1);
         if (sz == 0) begin
            ex_aluop = op; ex_mem_addr = addr; ex_reg2 = rt; ex_wd = wd; ex_wreg = wreg; ex_wdata = alu;
            @(negedge clk);
            n_checks++;
            if ({mem_wd, mem_wreg, mem_wdata, stallreq} !== {wd, wreg, alu, 1'b0}) begin
               n_fail++; $display("FAIL rnd_pass[%0d]: got %0d/%b/%h/%b want %0d/%b/%h/0", i,
                                  mem_wd, mem_wreg, mem_wdata, stallreq, wd, wreg, alu);
            end
            @(posedge clk); #1;
         end else if (addr % sz != 0) begin
            ex_aluop = op; ex_mem_addr = addr; ex_reg2 = rt; ex_wd = wd; ex_wreg = wreg; ex_wdata = alu;
            @(negedge clk);
            n_checks++;
            if ({addr_err, stallreq, dm_req, mem_wreg} !== 4'b1000) begin
               n_fail++; $display("FAIL rnd_misalign[%0d] op=%h addr=%h: got aerr/stall/req/wreg=%b%b%b%b want 1000",
                                  i, op, addr, addr_err, stallreq, dm_req, mem_wreg);
            end
            @(posedge clk); #1;
         end else begin
            run_op(op, addr, rt, wd, wreg, alu, rdata, dly, 1);
            n_checks++;
            if (!obs_done || obs_stall !== dly + 2 || obs_req !== dly + 1 || obs_addrerr !== 0 || obs_buserr !== 0) begin
               n_fail++; $display("FAIL rnd_timing[%0d] op=%h: got done=%0d stall=%0d req=%0d aerr=%0d berr=%0d want 1/%0d/%0d/0/0",
                                  i, op, obs_done, obs_stall, obs_req, obs_addrerr, obs_buserr, dly + 2, dly + 1);
            end
            n_checks++;
            if (obs_sel !== model_sel(op, addr) || obs_we !== op_store(op) || obs_dm_addr !== (addr & 32'hFFFF_FFFC)) begin
               n_fail++; $display("FAIL rnd_request[%0d] op=%h addr=%h: got sel=%b we=%b addr=%h want %b/%b/%h",
                                  i, op, addr, obs_sel, obs_we, obs_dm_addr, model_sel(op, addr), op_store(op), addr & 32'hFFFF_FFFC);
            end
            if (op_store(op)) begin
               n_checks++;
               if (obs_dm_wdata !== model_wdata(op, rt) || obs_wreg !== 1'b0) begin
                  n_fail++; $display("FAIL rnd_store[%0d] op=%h: got wdata=%h wreg=%b want %h/0",
                                     i, op, obs_dm_wdata, obs_wreg, model_wdata(op, rt));
               end
            end else begin
               n_checks++;
               if (obs_wdata !== model_load(op, addr, rdata) || obs_wreg !== wreg || obs_wd !== wd) begin
                  n_fail++; $display("FAIL rnd_load[%0d] op=%h addr=%h rdata=%h: got %h/%b/%0d want %h/%b/%0d",
                                     i, op, addr, rdata, obs_wdata, obs_wreg, obs_wd,
                                     model_load(op, addr, rdata), wreg, wd);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lb();
      test_sh();
      test_misaligned();
      test_timeout();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
